// File: rtl/formant_freq_stream.sv
// Formant angle to frequency converter with per-formant smoothing.
// One shared multiplier, one formant per cycle, valid/ready output stream.
module formant_freq_stream #(
    parameter int BIT_WIDTH   = 32,
    parameter int FORMANTS    = 5,
    parameter int SAMPLE_RATE = 16000,
    parameter int MAX_FREQ    = 5000,
    parameter int FREQ_WIDTH  = 16,
    parameter int ALPHA_SHIFT = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [BIT_WIDTH-1:0]  phi_1,
    input  logic [BIT_WIDTH-1:0]  phi_2,
    input  logic [BIT_WIDTH-1:0]  phi_3,
    input  logic [BIT_WIDTH-1:0]  phi_4,
    input  logic [BIT_WIDTH-1:0]  phi_5,
    input  logic                  phi_valid,
    output logic [FREQ_WIDTH-1:0] freq_data,
    output logic [2:0]            freq_index,
    output logic                  freq_last,
    output logic                  freq_clamped,
    output logic                  freq_valid,
    input  logic                  freq_ready,
    output logic                  busy,
    output logic [7:0]            overrun_count
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        EMIT
    } state_t;

    localparam int PW = BIT_WIDTH + 32;
    localparam logic [2:0] LAST = 3'(FORMANTS - 1);

    state_t state;
    state_t state_nxt;

    logic [2:0]            idx;
    logic [BIT_WIDTH-1:0]  phi_r [FORMANTS];
    logic [FREQ_WIDTH-1:0] y_r [FORMANTS];
    logic [FORMANTS-1:0]   clamp_r;
    logic                  primed;

    logic [PW-1:0]           prod;
    logic [PW-1:0]           raw;
    logic                    over;
    logic [FREQ_WIDTH-1:0]   f;
    logic [FREQ_WIDTH-1:0]   y_cur;
    logic [FREQ_WIDTH-1:0]   y_new;
    logic signed [FREQ_WIDTH:0] diff;
    logic signed [FREQ_WIDTH:0] step;
    logic signed [FREQ_WIDTH:0] y_cur_s;
    logic                    hs;
    logic                    last_beat;

    // Shared multiplier, clamp and smoothing step for the current formant
    always_comb begin
        prod    = PW'(phi_r[idx]) * PW'(SAMPLE_RATE / 2);
        raw     = prod >> BIT_WIDTH;
        over    = raw > PW'(MAX_FREQ);
        f       = over ? FREQ_WIDTH'(MAX_FREQ) : raw[FREQ_WIDTH-1:0];
        y_cur   = y_r[idx];
        y_cur_s = $signed({1'b0, y_cur});
        diff    = $signed({1'b0, f}) - y_cur_s;
        step    = diff >>> ALPHA_SHIFT;
        y_new   = primed ? FREQ_WIDTH'(y_cur_s + step) : f;
    end

    // Next-state logic and stream outputs
    always_comb begin
        state_nxt    = state;
        freq_valid   = 1'b0;
        freq_data    = '0;
        freq_index   = '0;
        freq_last    = 1'b0;
        freq_clamped = 1'b0;
        busy         = (state != IDLE);
        last_beat    = (idx == LAST);
        hs           = 1'b0;
        unique case (state)
            IDLE: begin
                if (phi_valid) state_nxt = CONVERT;
            end
            CONVERT: begin
                if (last_beat) state_nxt = EMIT;
            end
            EMIT: begin
                freq_valid   = 1'b1;
                freq_data    = y_cur;
                freq_index   = idx;
                freq_last    = last_beat;
                freq_clamped = clamp_r[idx];
                hs           = freq_ready;
                if (hs && last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // Frame latch, conversion results, beat index and overrun counter
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idx           <= '0;
            clamp_r       <= '0;
            primed        <= 1'b0;
            overrun_count <= '0;
            for (int i = 0; i < FORMANTS; i++) begin
                phi_r[i] <= '0;
                y_r[i]   <= '0;
            end
        end else begin
            if (phi_valid && state != IDLE && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;
            unique case (state)
                IDLE: begin
                    if (phi_valid) begin
                        phi_r[0] <= phi_1;
                        phi_r[1] <= phi_2;
                        phi_r[2] <= phi_3;
                        phi_r[3] <= phi_4;
                        phi_r[4] <= phi_5;
                        idx      <= '0;
                    end
                end
                CONVERT: begin
                    y_r[idx]     <= y_new;
                    clamp_r[idx] <= over;
                    if (last_beat) begin
                        primed <= 1'b1;
                        idx    <= '0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                EMIT: begin
                    if (hs) idx <= last_beat ? 3'd0 : idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_formant_freq_stream.sv
// Scoreboard bench for formant_freq_stream.
// Stimulus pushes hand-computed beats; a negedge monitor pops and compares.
module tb_formant_freq_stream;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] phi_1 = '0;
    logic [31:0] phi_2 = '0;
    logic [31:0] phi_3 = '0;
    logic [31:0] phi_4 = '0;
    logic [31:0] phi_5 = '0;
    logic        phi_valid = 1'b0;
    logic [15:0] freq_data;
    logic [2:0]  freq_index;
    logic        freq_last;
    logic        freq_clamped;
    logic        freq_valid;
    logic        freq_ready = 1'b1;
    logic        busy;
    logic [7:0]  overrun_count;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  i;
        logic        c;
    } beat_t;

    beat_t exp_q[$];

    formant_freq_stream dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .phi_1         (phi_1),
        .phi_2         (phi_2),
        .phi_3         (phi_3),
        .phi_4         (phi_4),
        .phi_5         (phi_5),
        .phi_valid     (phi_valid),
        .freq_data     (freq_data),
        .freq_index    (freq_index),
        .freq_last     (freq_last),
        .freq_clamped  (freq_clamped),
        .freq_valid    (freq_valid),
        .freq_ready    (freq_ready),
        .busy          (busy),
        .overrun_count (overrun_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_frame(input int d0, input int d1, input int d2,
                              input int d3, input int d4,
                              input logic [4:0] cm);
        int d[5];
        beat_t b;
        d = '{d0, d1, d2, d3, d4};
        for (int k = 0; k < 5; k++) begin
            b.d = 16'(d[k]);
            b.i = 3'(k);
            b.c = cm[k];
            exp_q.push_back(b);
        end
    endtask

    task automatic strobe(input logic [31:0] p1, input logic [31:0] p2,
                          input logic [31:0] p3, input logic [31:0] p4,
                          input logic [31:0] p5);
        @(posedge clk_in); #1;
        phi_1 = p1; phi_2 = p2; phi_3 = p3; phi_4 = p4; phi_5 = p5;
        phi_valid = 1'b1;
        @(posedge clk_in); #1;
        phi_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk_in); #1;
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        exp_q.delete();
        @(posedge clk_in); #1;
        rst_in = 1'b0;
    endtask

    // Monitor: stall stability and scoreboard comparison on each handshake
    logic        hold = 1'b0;
    logic [15:0] hold_d;
    logic [2:0]  hold_i;

    always @(negedge clk_in) begin
        beat_t e;
        if (rst_in) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("stall_valid", 32'(freq_valid), 32'd1);
                chk("stall_data", 32'(freq_data), 32'(hold_d));
                chk("stall_index", 32'(freq_index), 32'(hold_i));
            end
            if (freq_valid && freq_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(freq_data), 32'(e.d));
                    chk("beat_index", 32'(freq_index), 32'(e.i));
                    chk("beat_last", 32'(freq_last), 32'(e.i == 3'd4));
                    chk("beat_clamped", 32'(freq_clamped), 32'(e.c));
                end
            end
            hold   = freq_valid && !freq_ready;
            hold_d = freq_data;
            hold_i = freq_index;
        end
    end

    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_valid", 32'(freq_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(freq_data), 32'd0);
        chk("rst_index", 32'(freq_index), 32'd0);
        chk("rst_last", 32'(freq_last), 32'd0);
        chk("rst_clamped", 32'(freq_clamped), 32'd0);
        chk("rst_overrun", 32'(overrun_count), 32'd0);
        rst_in = 1'b0;

        // Basic conversion plus first-valid latency
        push_frame(4000, 2000, 0, 0, 0, 5'b00000);
        strobe(32'h8000_0000, 32'h4000_0000, 0, 0, 0);
        repeat (4) @(posedge clk_in);
        #1;
        chk("latency_early", 32'(freq_valid), 32'd0);
        @(posedge clk_in); #1;
        chk("latency_first", 32'(freq_valid), 32'd1);
        wait_idle("frame1_done");

        // Clamp of full-scale angle on formant 2, unprimed load
        do_reset();
        push_frame(0, 0, 5000, 0, 0, 5'b00100);
        strobe(0, 0, 32'hFFFF_FFFF, 0, 0);
        wait_idle("clamp_done");

        // Smoothing over three frames, backpressure in frame B
        do_reset();
        push_frame(4000, 0, 0, 0, 0, 5'b00000);
        strobe(32'h8000_0000, 0, 0, 0, 0);
        wait_idle("smoothA_done");
        push_frame(3000, 0, 0, 0, 0, 5'b00000);
        strobe(0, 0, 0, 0, 0);
        repeat (6) @(posedge clk_in);
        #1;
        chk("bp_index", 32'(freq_index), 32'd1);
        freq_ready = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        freq_ready = 1'b1;
        wait_idle("smoothB_done");
        push_frame(2250, 0, 0, 0, 0, 5'b00000);
        strobe(0, 0, 0, 0, 0);
        wait_idle("smoothC_done");

        // Overrun strobes during CONVERT and on the final handshake
        do_reset();
        push_frame(2000, 0, 0, 0, 0, 5'b00000);
        strobe(32'h4000_0000, 0, 0, 0, 0);
        @(posedge clk_in); #1;
        phi_1 = 32'hFFFF_FFFF;
        phi_valid = 1'b1;
        @(posedge clk_in); #1;
        phi_valid = 1'b0;
        phi_1 = '0;
        repeat (7) @(posedge clk_in);
        #1;
        chk("ovr_final_beat", 32'(freq_last), 32'd1);
        phi_1 = 32'hFFFF_FFFF;
        phi_valid = 1'b1;
        @(posedge clk_in); #1;
        phi_valid = 1'b0;
        phi_1 = '0;
        chk("ovr_count", 32'(overrun_count), 32'd2);
        chk("ovr_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk_in);
        #1;
        chk("ovr_stays_idle", 32'(busy), 32'd0);

        // Reset during beat 2 of a primed frame (would give 2500 then 1875)
        push_frame(2500, 0, 0, 0, 0, 5'b00000);
        strobe(32'h8000_0000, 0, 0, 0, 0);
        repeat (7) @(posedge clk_in);
        #1;
        chk("mid_rst_index", 32'(freq_index), 32'd2);
        rst_in = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", 32'(freq_valid), 32'd0);
        chk("mid_rst_overrun", 32'(overrun_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        push_frame(0, 0, 0, 0, 0, 5'b00000);
        strobe(0, 0, 0, 0, 0);
        wait_idle("post_rst_done");

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
